// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX_BYTE,
    ST_RX_ACK,
    ST_TX_BYTE,
    ST_TX_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic       I2C_ACK  = 1'b0;
  localparam logic       I2C_NACK = 1'b1;
  localparam int         RW_BIT   = 0;      // R/W flag position in the address byte
  localparam logic [2:0] BIT_MSB  = 3'd7;   // bit counter start / wrap value

endpackage

// File: rtl/i2c_in_filter.sv
// Synchroniser plus glitch filter for one I2C line, with registered edge flags.
// Idle level is high, so everything resets to 1.
module i2c_in_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser for the asynchronous bus pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= pin;
      sync_p1 <= sync_p0;
    end
  end

  // Accept a new level only after FILTER_LEN identical samples; flag the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
        level <= sync_p1;
        cnt   <= '0;
        rise  <= sync_p1;
        fall  <= ~sync_p1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_slave.sv
// I2C target for one 7-bit address: START/STOP detection, address match,
// byte receive with strobe, byte transmit from host logic. Open-drain SDA.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h55,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       addressed,
  output logic       error
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_ev, stop_ev;

  i2c_state_e state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic       got_bit, got_bit_nx;   // a rising SCL was seen in the current bit slot
  logic [7:0] shreg, shreg_nx;
  logic [6:0] txsh, txsh_nx;         // bits still to be sent after the one on the bus
  logic       rw, rw_nx;
  logic       sda_oe, sda_oe_nx;     // 1 = pull SDA low
  logic [7:0] rx_data_nx;
  logic       rx_valid_nx, tx_ready_nx, busy_nx, addressed_nx, error_nx;
  logic [7:0] tx_byte;

  function automatic logic [7:0] tx_pick(input logic vld, input logic [7:0] data);
    return vld ? data : 8'hFF;
  endfunction

  i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .rst(rst), .pin(scl), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .rst(rst), .pin(sda), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  // Reset gates the drive directly so SDA lets go without waiting for a clock.
  assign sda = (sda_oe && rst) ? 1'b0 : 1'bz;

  assign start_ev = sda_fall && scl_lvl;
  assign stop_ev  = sda_rise && scl_lvl;
  assign tx_byte  = tx_pick(tx_valid, tx_data);

  // Next-state and output logic; bus conditions take priority over SCL edges.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    got_bit_nx   = got_bit;
    shreg_nx     = shreg;
    txsh_nx      = txsh;
    rw_nx        = rw;
    sda_oe_nx    = sda_oe;
    rx_data_nx   = rx_data;
    rx_valid_nx  = 1'b0;
    tx_ready_nx  = 1'b0;
    busy_nx      = busy;
    addressed_nx = addressed;
    error_nx     = error;

    if (start_ev || stop_ev) begin
      // A counter away from its start value means a byte was cut short.
      if (cnt != BIT_MSB) error_nx = 1'b1;
      cnt_nx       = BIT_MSB;
      got_bit_nx   = 1'b0;
      sda_oe_nx    = 1'b0;
      addressed_nx = 1'b0;
      busy_nx      = start_ev;
      state_nx     = start_ev ? ST_ADDR : ST_IDLE;
    end else begin
      case (state)
        ST_ADDR, ST_RX_BYTE: begin
          if (scl_rise) begin
            shreg_nx   = {shreg[6:0], sda_lvl};
            got_bit_nx = 1'b1;
            if (state == ST_RX_BYTE && cnt == 3'd0) begin
              rx_data_nx  = {shreg[6:0], sda_lvl};
              rx_valid_nx = 1'b1;
            end
          end else if (scl_fall && got_bit) begin
            got_bit_nx = 1'b0;
            if (cnt != 3'd0) begin
              cnt_nx = cnt - 3'd1;
            end else begin
              cnt_nx = BIT_MSB;
              if (state == ST_RX_BYTE) begin
                sda_oe_nx = 1'b1;
                state_nx  = ST_RX_ACK;
              end else if (shreg[7:1] == SLAVE_ADDR) begin
                sda_oe_nx = 1'b1;
                rw_nx     = shreg[RW_BIT];
                state_nx  = ST_ADDR_ACK;
              end else begin
                state_nx  = ST_IGNORE;
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_nx    = 1'b0;
            addressed_nx = 1'b1;
            if (rw) begin
              txsh_nx     = tx_byte[6:0];
              sda_oe_nx   = ~tx_byte[7];
              tx_ready_nx = tx_valid;
              if (!tx_valid) error_nx = 1'b1;
              state_nx    = ST_TX_BYTE;
            end else begin
              state_nx    = ST_RX_BYTE;
            end
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            sda_oe_nx = 1'b0;
            state_nx  = ST_RX_BYTE;
          end
        end
        ST_TX_BYTE: begin
          if (scl_fall) begin
            if (cnt == 3'd0) begin
              sda_oe_nx = 1'b0;
              cnt_nx    = BIT_MSB;
              state_nx  = ST_TX_ACK;
            end else begin
              cnt_nx    = cnt - 3'd1;
              sda_oe_nx = ~txsh[6];
              txsh_nx   = {txsh[5:0], 1'b1};
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise && sda_lvl == I2C_NACK) begin
            state_nx = ST_IGNORE;
          end else if (scl_fall) begin
            txsh_nx     = tx_byte[6:0];
            sda_oe_nx   = ~tx_byte[7];
            tx_ready_nx = tx_valid;
            if (!tx_valid) error_nx = 1'b1;
            state_nx    = ST_TX_BYTE;
          end
        end
        default: ;
      endcase
    end
  end

  // State, shifters and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= BIT_MSB;
      got_bit   <= 1'b0;
      shreg     <= 8'h00;
      txsh      <= 7'h7F;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_ready  <= 1'b0;
      busy      <= 1'b0;
      addressed <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      got_bit   <= got_bit_nx;
      shreg     <= shreg_nx;
      txsh      <= txsh_nx;
      rw        <= rw_nx;
      sda_oe    <= sda_oe_nx;
      rx_data   <= rx_data_nx;
      rx_valid  <= rx_valid_nx;
      tx_ready  <= tx_ready_nx;
      busy      <= busy_nx;
      addressed <= addressed_nx;
      error     <= error_nx;
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bus-level master model, scoreboard queues for received
// and read-back bytes, directed scenarios plus randomized transactions.
module tb_i2c_slave;

  localparam logic [6:0] SA = 7'h55;
  localparam int         Q  = 20;   // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_pin;
  logic       m_low;
  wire        sda_bus;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       addressed;
  logic       error;

  pullup (sda_bus);
  assign sda_bus = m_low ? 1'b0 : 1'bz;

  int checks   = 0;
  int failures = 0;
  int txr_seen = 0;
  int exp_txr  = 0;

  logic [7:0] rx_q[$];
  logic [7:0] rd_q[$];

  i2c_slave #(.SLAVE_ADDR(SA), .FILTER_LEN(3)) dut (
    .clk(clk), .rst(rst), .scl(scl_pin), .sda(sda_bus),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .addressed(addressed), .error(error)
  );

  always #4 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference rules: ACK only for the configured address; unsupplied read data reads as 0xFF.
  function automatic logic exp_ack(input logic [6:0] a);
    return (a == SA) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [7:0] bus_byte(input logic [7:0] d, input logic v);
    return v ? d : 8'hFF;
  endfunction

  // Monitor: every rx_valid strobe is matched against the oldest expected byte.
  always @(negedge clk) begin
    if (rst && rx_valid) begin
      if (rx_q.size() == 0) chk("rx_unexpected", {24'h0, rx_data}, 32'hFFFF_FFFF);
      else chk("rx_data", {24'h0, rx_data}, {24'h0, rx_q.pop_front()});
    end
    if (rst && tx_ready) txr_seen++;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: timeout, got %0d checks, expected completion", checks);
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    m_low = ~b;
    wait_clk(Q);
    scl_pin = 1'b1;
    wait_clk(Q);
    s = sda_bus;
    wait_clk(Q);
    scl_pin = 1'b0;
    wait_clk(Q);
  endtask

  task automatic bus_start();
    m_low = 1'b0;
    wait_clk(Q);
    scl_pin = 1'b1;
    wait_clk(Q);
    m_low = 1'b1;
    wait_clk(Q);
    scl_pin = 1'b0;
    wait_clk(Q);
  endtask

  task automatic bus_stop();
    m_low = 1'b1;
    wait_clk(Q);
    scl_pin = 1'b1;
    wait_clk(Q);
    m_low = 1'b0;
    wait_clk(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic [7:0] nxt, input logic nv, input logic ack_bit,
                           output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(1'b1, b[i]);
    if (rd_q.size() == 0) chk("rd_unexpected", {24'h0, b}, 32'hFFFF_FFFF);
    else chk("rd_byte", {24'h0, b}, {24'h0, rd_q.pop_front()});
    tx_data  = nxt;
    tx_valid = nv;
    clock_bit(ack_bit, s);
  endtask

  initial begin
    logic       ack, s, is_rd, match;
    logic [6:0] a7;
    logic [7:0] b, d, nxt;
    int         n;

    rst = 1'b0; scl_pin = 1'b1; m_low = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    wait_clk(5);
    chk("rst_sda", sda_bus, 1'b1);
    chk("rst_tx_ready", tx_ready, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addressed", addressed, 1'b0);
    chk("rst_error", error, 1'b0);
    rst = 1'b1;
    wait_clk(10);

    // One-clock SDA glitch while SCL idles high.
    m_low = 1'b1;
    wait_clk(1);
    m_low = 1'b0;
    wait_clk(20);
    chk("glitch_busy", busy, 1'b0);

    // Wrong address 0x2A write.
    bus_start();
    write_byte(8'h54, ack);
    chk("t1_ack", ack, exp_ack(7'h2A));
    chk("t1_busy", busy, 1'b1);
    chk("t1_addressed", addressed, 1'b0);
    bus_stop();
    chk("t1_busy_end", busy, 1'b0);

    // Write two bytes.
    bus_start();
    write_byte(8'hAA, ack);
    chk("t2_addr_ack", ack, 1'b0);
    chk("t2_addressed", addressed, 1'b1);
    rx_q.push_back(8'h11);
    write_byte(8'h11, ack);
    chk("t2_ack1", ack, 1'b0);
    rx_q.push_back(8'h22);
    write_byte(8'h22, ack);
    chk("t2_ack2", ack, 1'b0);
    bus_stop();
    chk("t2_busy_end", busy, 1'b0);
    chk("t2_addressed_end", addressed, 1'b0);

    // Read two bytes, master ACK then NACK.
    tx_data = 8'hDC; tx_valid = 1'b1;
    rd_q.push_back(bus_byte(8'hDC, 1'b1));
    bus_start();
    write_byte(8'hAB, ack);
    chk("t3_addr_ack", ack, 1'b0);
    rd_q.push_back(bus_byte(8'hAA, 1'b1));
    read_byte(8'hAA, 1'b1, 1'b0, b);
    read_byte(8'h00, 1'b1, 1'b1, b);
    exp_txr += 2;
    wait_clk(10);
    chk("t3_sda_released", sda_bus, 1'b1);
    chk("t3_tx_ready_cnt", txr_seen, exp_txr);
    bus_stop();

    // Write then repeated START into a read.
    bus_start();
    write_byte(8'hAA, ack);
    rx_q.push_back(8'h33);
    write_byte(8'h33, ack);
    chk("t5_ack", ack, 1'b0);
    tx_data = 8'h5A; tx_valid = 1'b1;
    rd_q.push_back(bus_byte(8'h5A, 1'b1));
    bus_start();
    chk("t5_busy_rs", busy, 1'b1);
    chk("t5_addressed_rs", addressed, 1'b0);
    write_byte(8'hAB, ack);
    chk("t5_addr_ack", ack, 1'b0);
    chk("t5_addressed", addressed, 1'b1);
    read_byte(8'h00, 1'b1, 1'b1, b);
    exp_txr += 1;
    chk("t5_rx_data", rx_data, 8'h33);
    chk("t5_busy", busy, 1'b1);
    bus_stop();
    chk("t5_tx_ready_cnt", txr_seen, exp_txr);

    // Randomized transactions.
    for (int t = 0; t < 6; t++) begin
      is_rd = 1'($urandom_range(0, 1));
      match = ($urandom_range(0, 3) != 0);
      a7    = match ? SA : 7'($urandom_range(0, 127));
      if (a7 == SA && !match) a7 = a7 ^ 7'h01;
      n     = $urandom_range(1, 3);
      d     = 8'($urandom);
      tx_data = d; tx_valid = 1'b1;
      if (is_rd && a7 == SA) rd_q.push_back(bus_byte(d, 1'b1));
      bus_start();
      write_byte({a7, is_rd}, ack);
      chk("rnd_addr_ack", ack, exp_ack(a7));
      chk("rnd_addressed", addressed, (a7 == SA) ? 1'b1 : 1'b0);
      if (a7 == SA) begin
        for (int k = 0; k < n; k++) begin
          if (is_rd) begin
            nxt = 8'($urandom);
            if (k < n - 1) rd_q.push_back(bus_byte(nxt, 1'b1));
            read_byte(nxt, 1'b1, (k == n - 1) ? 1'b1 : 1'b0, b);
          end else begin
            d = 8'($urandom);
            rx_q.push_back(d);
            write_byte(d, ack);
            chk("rnd_data_ack", ack, 1'b0);
          end
        end
        if (is_rd) exp_txr += n;
      end
      bus_stop();
      chk("rnd_busy_end", busy, 1'b0);
    end
    chk("rnd_tx_ready_cnt", txr_seen, exp_txr);
    chk("no_error_yet", error, 1'b0);

    // Read with no data supplied.
    tx_valid = 1'b0; tx_data = 8'h12;
    rd_q.push_back(bus_byte(8'h12, 1'b0));
    bus_start();
    write_byte(8'hAB, ack);
    read_byte(8'h12, 1'b0, 1'b1, b);
    chk("t4_error", error, 1'b1);
    bus_stop();
    chk("t4_error_sticky", error, 1'b1);
    chk("t4_tx_ready_cnt", txr_seen, exp_txr);

    // Reset while the target is pulling SDA low during a read.
    tx_data = 8'h00; tx_valid = 1'b1;
    bus_start();
    write_byte(8'hAB, ack);
    exp_txr += 1;
    clock_bit(1'b1, s);
    clock_bit(1'b1, s);
    chk("t6_driving", sda_bus, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("t6_sda_released", sda_bus, 1'b1);
    chk("t6_busy", busy, 1'b0);
    chk("t6_error", error, 1'b0);
    chk("t6_rx_data", rx_data, 8'h00);
    chk("t6_addressed", addressed, 1'b0);
    chk("t6_tx_ready", tx_ready, 1'b0);
    scl_pin = 1'b1; m_low = 1'b0; tx_valid = 1'b0;
    wait_clk(10);
    rst = 1'b1;
    wait_clk(10);
    bus_start();
    write_byte(8'hAA, ack);
    chk("t6_post_ack", ack, 1'b0);
    rx_q.push_back(8'h77);
    write_byte(8'h77, ack);
    bus_stop();
    chk("t6_post_rx", rx_data, 8'h77);

    // STOP three bits into a byte.
    chk("mid_err_before", error, 1'b0);
    bus_start();
    write_byte(8'hAA, ack);
    clock_bit(1'b1, s);
    clock_bit(1'b0, s);
    clock_bit(1'b1, s);
    bus_stop();
    chk("mid_err_after", error, 1'b1);
    chk("mid_busy", busy, 1'b0);

    chk("rx_q_empty", rx_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("final_tx_ready_cnt", txr_seen, exp_txr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
